// File: rtl/circuit_3_pipe_pkg.sv
// circuit_pkg: shared definitions for circuit_3_pipe.
//   EvalW         - widest vector circuit3_eval handles; instances must keep WIDTH <= EvalW
//   clog2()       - ceil(log2(value)), used to size the popcount adder
//   circuit3_eval - gate-level NAND/XOR/NOT/OR/NOR network, applied bitwise
package circuit_pkg;

    localparam int unsigned EvalW = 64;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        int unsigned span;
        res  = 0;
        span = 1;
        while (span < value) begin
            span = span << 1;
            res  = res + 1;
        end
        return res;
    endfunction

    // Kept in gate form on purpose; it reduces to a & b & ~c.
    function automatic logic [EvalW-1:0] circuit3_eval(input logic [EvalW-1:0] a,
                                                       input logic [EvalW-1:0] b,
                                                       input logic [EvalW-1:0] c);
        logic [EvalW-1:0] w;
        logic [EvalW-1:0] y;
        logic [EvalW-1:0] n;
        logic [EvalW-1:0] z;
        w = ~(a & b);
        y = w ^ c;
        n = ~a;
        z = n | y;
        return ~(z | c);
    endfunction

endpackage

// File: rtl/circuit_3_pipe_if.sv
// circuit_3_pipe_if: stream and counter signals of circuit_3_pipe.
//   in_valid/in_ready/a/b/c   - upstream operand stream
//   out_valid/out_ready/o     - downstream result stream
//   cnt_clear/ones_cnt        - delivered-ones counter control and value
// master: stimulus/sink side. slave: the pipeline.
interface circuit_3_pipe_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] o;
    logic             cnt_clear;
    logic [CNT_W-1:0] ones_cnt;

    modport master (
        output in_valid, a, b, c, out_ready, cnt_clear,
        input  in_ready, out_valid, o, ones_cnt
    );

    modport slave (
        input  in_valid, a, b, c, out_ready, cnt_clear,
        output in_ready, out_valid, o, ones_cnt
    );
endinterface

// File: rtl/circuit_3_pipe_stage.sv
// pipe_stage: one valid bit plus WIDTH data bits; loads when en, holds otherwise.
//   clk, rst_n        - clock, async active-low reset (clears valid and data)
//   en                - load d_valid/d_data this edge
//   d_valid, d_data   - incoming stage contents
//   q_valid, q_data   - registered stage contents
module pipe_stage #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             d_valid,
    input  logic [WIDTH-1:0] d_data,
    output logic             q_valid,
    output logic [WIDTH-1:0] q_data
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_valid <= 1'b0;
            q_data  <= '0;
        end else if (en) begin
            q_valid <= d_valid;
            q_data  <= d_data;
        end
    end
endmodule

// File: rtl/circuit_3_pipe.sv
// circuit_3_pipe: STAGES-deep valid/ready pipeline computing the three-input gate network
// bitwise on a/b/c, plus a saturating count of 1-bits in delivered results.
//   clk, rst_n - clock, async active-low reset
//   bus        - circuit_3_pipe_if.slave: operand stream in, result stream out, counter
module circuit_3_pipe
    import circuit_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 3,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    circuit_3_pipe_if.slave   bus
);
    localparam int unsigned PopW = clog2(WIDTH + 1);

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] adv;
    logic [WIDTH-1:0]  data [STAGES];
    logic [EvalW-1:0]  eval_full;
    logic [WIDTH-1:0]  eval;

    assign eval_full = circuit3_eval(EvalW'(bus.a), EvalW'(bus.b), EvalW'(bus.c));
    assign eval      = eval_full[WIDTH-1:0];

    // A stage may advance if it is empty or its successor advances; this ripples
    // out_ready back to in_ready with no skid buffer.
    always_comb begin
        logic carry;
        adv   = '0;
        carry = ~v[STAGES-1] | bus.out_ready;
        adv[STAGES-1] = carry;
        for (int k = int'(STAGES) - 2; k >= 0; k--) begin
            carry  = ~v[k] | carry;
            adv[k] = carry;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             d_valid;
        logic [WIDTH-1:0] d_data;
        if (k == 0) begin : g_first
            assign d_valid = bus.in_valid;
            assign d_data  = eval;
        end else begin : g_next
            assign d_valid = v[k-1];
            assign d_data  = data[k-1];
        end
        pipe_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (adv[k]),
            .d_valid (d_valid),
            .d_data  (d_data),
            .q_valid (v[k]),
            .q_data  (data[k])
        );
    end

    assign bus.in_ready  = adv[0];
    assign bus.out_valid = v[STAGES-1];
    assign bus.o         = data[STAGES-1];

    // Delivered-ones counter
    logic [PopW-1:0]  pop;
    logic [CNT_W:0]   sum;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             out_xfer;

    always_comb begin
        pop = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            pop = pop + PopW'(data[STAGES-1][i]);
        end
    end

    assign out_xfer = v[STAGES-1] & bus.out_ready;
    assign sum      = {1'b0, cnt_q} + (CNT_W + 1)'(pop);

    always_comb begin
        cnt_d = cnt_q;
        if (bus.cnt_clear) begin
            cnt_d = '0;
        end else if (out_xfer) begin
            cnt_d = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.ones_cnt = cnt_q;
endmodule

// File: tb/tb_circuit_3_pipe.sv
module tb_circuit_3_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    circuit_3_pipe_if #(.WIDTH(1), .CNT_W(16)) bus1 ();
    circuit_3_pipe_if #(.WIDTH(8), .CNT_W(16)) bus2 ();
    circuit_3_pipe_if #(.WIDTH(8), .CNT_W(4))  bus3 ();

    circuit_3_pipe #(.WIDTH(1), .STAGES(1), .CNT_W(16)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );
    circuit_3_pipe #(.WIDTH(8), .STAGES(3), .CNT_W(16)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.slave)
    );
    circuit_3_pipe #(.WIDTH(8), .STAGES(3), .CNT_W(4)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        checks++; if (bus2.in_ready !== 1'b1) begin errors++;
            $display("FAIL rst_in_ready got %b want 1", bus2.in_ready); end
        checks++; if (bus2.out_valid !== 1'b0) begin errors++;
            $display("FAIL rst_out_valid got %b want 0", bus2.out_valid); end
        checks++; if (bus2.o !== 8'h00) begin errors++;
            $display("FAIL rst_o got %h want 00", bus2.o); end
        checks++; if (bus2.ones_cnt !== 16'd0) begin errors++;
            $display("FAIL rst_ones_cnt got %0d want 0", bus2.ones_cnt); end
        checks++; if (bus1.in_ready !== 1'b1) begin errors++;
            $display("FAIL rst_in_ready1 got %b want 1", bus1.in_ready); end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_exhaustive();
        logic [2:0] abc;
        logic       exp;
        bus1.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            abc = 3'(i);
            exp = abc[2] & abc[1] & ~abc[0];
            bus1.a = abc[2];
            bus1.b = abc[1];
            bus1.c = abc[0];
            bus1.in_valid = 1'b1;
            checks++; if (bus1.in_ready !== 1'b1) begin errors++;
                $display("FAIL exh_in_ready[%0d] got %b want 1", i, bus1.in_ready); end
            tick();
            checks++; if (bus1.out_valid !== 1'b1) begin errors++;
                $display("FAIL exh_out_valid[%0d] got %b want 1", i, bus1.out_valid); end
            checks++; if (bus1.o !== exp) begin errors++;
                $display("FAIL exh_o[%0d] got %b want %b", i, bus1.o, exp); end
        end
        bus1.in_valid = 1'b0;
        tick();
        checks++; if (bus1.out_valid !== 1'b0) begin errors++;
            $display("FAIL exh_drain got %b want 0", bus1.out_valid); end
        checks++; if (bus1.ones_cnt !== 16'd1) begin errors++;
            $display("FAIL exh_ones_cnt got %0d want 1", bus1.ones_cnt); end
    endtask

    task automatic test_streaming();
        bus2.out_ready = 1'b1;
        bus2.in_valid  = 1'b1;
        bus2.a = 8'hFF; bus2.b = 8'hF0; bus2.c = 8'h30;
        tick();
        bus2.a = 8'h0F; bus2.b = 8'h0F; bus2.c = 8'h00;
        tick();
        bus2.in_valid = 1'b0;
        checks++; if (bus2.out_valid !== 1'b0) begin errors++;
            $display("FAIL stream_early got %b want 0", bus2.out_valid); end
        tick();
        checks++; if (bus2.out_valid !== 1'b1 || bus2.o !== 8'hC0) begin errors++;
            $display("FAIL stream_first got v=%b o=%h want v=1 o=c0", bus2.out_valid, bus2.o); end
        tick();
        checks++; if (bus2.out_valid !== 1'b1 || bus2.o !== 8'h0F) begin errors++;
            $display("FAIL stream_second got v=%b o=%h want v=1 o=0f", bus2.out_valid, bus2.o); end
        checks++; if (bus2.ones_cnt !== 16'd2) begin errors++;
            $display("FAIL stream_cnt_mid got %0d want 2", bus2.ones_cnt); end
        tick();
        checks++; if (bus2.out_valid !== 1'b0) begin errors++;
            $display("FAIL stream_drain got %b want 0", bus2.out_valid); end
        checks++; if (bus2.ones_cnt !== 16'd6) begin errors++;
            $display("FAIL stream_cnt got %0d want 6", bus2.ones_cnt); end
    endtask

    task automatic test_backpressure();
        logic [7:0] vals [4];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
        bus2.out_ready = 1'b0;
        bus2.a = 8'hFF; bus2.c = 8'h00;
        for (int i = 0; i < 3; i++) begin
            bus2.b = vals[i];
            bus2.in_valid = 1'b1;
            checks++; if (bus2.in_ready !== 1'b1) begin errors++;
                $display("FAIL bp_accept[%0d] got %b want 1", i, bus2.in_ready); end
            tick();
        end
        bus2.b = vals[3];
        for (int i = 0; i < 5; i++) begin
            checks++; if (bus2.in_ready !== 1'b0) begin errors++;
                $display("FAIL bp_full[%0d] got %b want 0", i, bus2.in_ready); end
            checks++; if (bus2.out_valid !== 1'b1 || bus2.o !== 8'h11) begin errors++;
                $display("FAIL bp_hold[%0d] got v=%b o=%h want v=1 o=11", i, bus2.out_valid,
                         bus2.o); end
            tick();
        end
        bus2.in_valid  = 1'b0;
        bus2.out_ready = 1'b1;
        #1;
        checks++; if (bus2.in_ready !== 1'b1) begin errors++;
            $display("FAIL bp_release_ready got %b want 1", bus2.in_ready); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus2.out_valid !== 1'b1 || bus2.o !== vals[i]) begin errors++;
                $display("FAIL bp_order[%0d] got v=%b o=%h want v=1 o=%h", i, bus2.out_valid,
                         bus2.o, vals[i]); end
            tick();
        end
        checks++; if (bus2.out_valid !== 1'b0) begin errors++;
            $display("FAIL bp_drain got %b want 0", bus2.out_valid); end
        checks++; if (bus2.ones_cnt !== 16'd14) begin errors++;
            $display("FAIL bp_cnt got %0d want 14", bus2.ones_cnt); end
    endtask

    task automatic test_clear_race();
        bus2.out_ready = 1'b0;
        bus2.a = 8'hFF; bus2.b = 8'h03; bus2.c = 8'h00;
        bus2.in_valid = 1'b1;
        tick();
        bus2.in_valid = 1'b0;
        tick();
        tick();
        checks++; if (bus2.out_valid !== 1'b1 || bus2.o !== 8'h03) begin errors++;
            $display("FAIL clr_pre got v=%b o=%h want v=1 o=03", bus2.out_valid, bus2.o); end
        checks++; if (bus2.ones_cnt !== 16'd14) begin errors++;
            $display("FAIL clr_pre_cnt got %0d want 14", bus2.ones_cnt); end
        bus2.cnt_clear = 1'b1;
        bus2.out_ready = 1'b1;
        tick();
        bus2.cnt_clear = 1'b0;
        checks++; if (bus2.ones_cnt !== 16'd0) begin errors++;
            $display("FAIL clr_cnt got %0d want 0", bus2.ones_cnt); end
        checks++; if (bus2.out_valid !== 1'b0) begin errors++;
            $display("FAIL clr_xfer got %b want 0", bus2.out_valid); end
    endtask

    task automatic test_saturation();
        bus3.out_ready = 1'b1;
        bus3.a = 8'hFF; bus3.b = 8'hFF; bus3.c = 8'h00;
        bus3.in_valid = 1'b1;
        tick();
        tick();
        tick();
        bus3.in_valid = 1'b0;
        tick();
        checks++; if (bus3.ones_cnt !== 4'd8) begin errors++;
            $display("FAIL sat_first got %0d want 8", bus3.ones_cnt); end
        tick();
        checks++; if (bus3.ones_cnt !== 4'd15) begin errors++;
            $display("FAIL sat_second got %0d want 15", bus3.ones_cnt); end
        tick();
        checks++; if (bus3.ones_cnt !== 4'd15) begin errors++;
            $display("FAIL sat_third got %0d want 15", bus3.ones_cnt); end
        checks++; if (bus3.out_valid !== 1'b0) begin errors++;
            $display("FAIL sat_drain got %b want 0", bus3.out_valid); end
    endtask

    task automatic test_reset_midstream();
        bus2.out_ready = 1'b0;
        bus2.a = 8'hFF; bus2.b = 8'hFF; bus2.c = 8'h00;
        bus2.in_valid = 1'b1;
        tick();
        bus2.b = 8'h0F;
        tick();
        bus2.in_valid = 1'b0;
        tick();
        checks++; if (bus2.out_valid !== 1'b1 || bus2.o !== 8'hFF) begin errors++;
            $display("FAIL rmid_pre got v=%b o=%h want v=1 o=ff", bus2.out_valid, bus2.o); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus2.out_valid !== 1'b0 || bus2.o !== 8'h00) begin errors++;
            $display("FAIL rmid_flush got v=%b o=%h want v=0 o=00", bus2.out_valid, bus2.o); end
        checks++; if (bus2.in_ready !== 1'b1) begin errors++;
            $display("FAIL rmid_in_ready got %b want 1", bus2.in_ready); end
        checks++; if (bus3.ones_cnt !== 4'd0) begin errors++;
            $display("FAIL rmid_cnt got %0d want 0", bus3.ones_cnt); end
        tick();
        rst_n = 1'b1;
        bus2.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (bus2.out_valid !== 1'b0) begin errors++;
                $display("FAIL rmid_stale[%0d] got %b want 0", i, bus2.out_valid); end
        end
        checks++; if (bus2.ones_cnt !== 16'd0) begin errors++;
            $display("FAIL rmid_cnt_after got %0d want 0", bus2.ones_cnt); end
    endtask

    initial begin
        bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.c = '0;
        bus1.out_ready = 1'b0; bus1.cnt_clear = 1'b0;
        bus2.in_valid = 1'b0; bus2.a = '0; bus2.b = '0; bus2.c = '0;
        bus2.out_ready = 1'b0; bus2.cnt_clear = 1'b0;
        bus3.in_valid = 1'b0; bus3.a = '0; bus3.b = '0; bus3.c = '0;
        bus3.out_ready = 1'b0; bus3.cnt_clear = 1'b0;
        test_reset();
        test_exhaustive();
        test_streaming();
        test_backpressure();
        test_clear_race();
        test_saturation();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/circuit_3_pipe.md
Name: circuit_3_pipe

Overview:
- Clocked, parametrised successor of the three-input gate network (NAND, XOR, NOT, OR, NOR).
- Evaluates the same Boolean function bitwise on WIDTH-bit vectors a, b, c through a STAGES-deep valid/ready pipeline.
- Keeps a saturating count of asserted result bits delivered downstream.
- Sits between a stimulus source and a result sink in the simulator test fabric; replaces per-gate propagation delays with cycle latency.

Parameters:
- WIDTH, 8, lanes per vector (>=1)
- STAGES, 3, pipeline register stages, equal to latency in cycles (>=1)
- CNT_W, 16, width of the delivered-ones counter (>=1)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  a/b/c hold a valid vector
- in_ready  output  1  pipeline accepts the vector this cycle
- a  input  WIDTH  operand a
- b  input  WIDTH  operand b
- c  input  WIDTH  operand c
- out_valid  output  1  o holds a valid result
- out_ready  input  1  sink accepts o this cycle
- o  output  WIDTH  result vector
- cnt_clear  input  1  synchronous clear of ones_cnt
- ones_cnt  output  CNT_W  saturating count of 1-bits in all delivered o vectors

Behaviour:
- Per-lane function, evaluated combinationally before stage 0 register:
  - w = ~(a&b)
  - y = w^c
  - n = ~a
  - z = n|y
  - o = ~(z|c)
  - Net result: o = a & b & ~c. Implement the gate form; the bench checks against the reduced form.
- Transfers:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
- Stage occupancy:
  - Each stage k holds valid bit v[k] and WIDTH data bits.
  - adv[STAGES-1] = ~v[STAGES-1] | out_ready
  - adv[k] = ~v[k] | adv[k+1]
  - in_ready = adv[0]: combinational from out_ready through the chain; no registered skid.
  - When adv[k]: v[k] <= v[k-1] (v[-1] = in_valid) and data moves forward. When ~adv[k], stage k holds.
- Timing and throughput:
  - Latency: vector accepted at edge t appears on o with out_valid=1 after edge t+STAGES-1, i.e. out_valid visible in cycle t+STAGES, when no stall occurs.
  - Throughput: one vector per cycle under continuous out_ready=1.
  - Capacity: exactly STAGES vectors.
- Stall rules:
  - While out_valid=1 and out_ready=0, o and out_valid hold stable.
  - No vector is dropped, duplicated or reordered.
  - Data of empty stages is don't-care, but o is registered.
- Counter:
  - On each output transfer, ones_cnt <= min(ones_cnt + popcount(o), 2^CNT_W-1).
  - The popcount adder is sized ceil(log2(WIDTH+1)) bits, zero-extended; the sum is computed in CNT_W+1 bits before saturating.
- cnt_clear:
  - ones_cnt <= 0 that cycle and the same-cycle transfer is not counted (clear wins).
  - Pipeline is unaffected.
- Reset (async assert, sync-released by the environment):
  - All v[k]=0, out_valid=0, o=0, ones_cnt=0.
  - in_ready is 1 as soon as rst_n=0, because it derives from empty stages.
  - Reset mid-stream discards all in-flight vectors without any output transfer.
- in_valid / in_ready rules:
  - in_valid may be asserted without waiting for in_ready.
  - The source must hold a/b/c until transfer; the block does not check this.

Decomposition:
- Shared package circuit_pkg:
  - function circuit3_eval(a,b,c) returning the gate-level result, so the bench model and RTL share one definition.
  - Localparam helper CLOG2 for the popcount width.
- One sub-module, pipe_stage: one valid/data register with a hold-enable.
- The top instantiates STAGES copies in a generate loop, plus the counter logic.

Test Plan:
- Exhaustive single lane, WIDTH=1, STAGES=1: all 8 (a,b,c) combinations, out_ready=1 -> o=1 only for a=1,b=1,c=0; each result appears one cycle after acceptance; final ones_cnt=1.
- Streaming, WIDTH=8, STAGES=3: a=8'hFF, b=8'hF0, c=8'h30 then a=8'h0F, b=8'h0F, c=8'h00 back-to-back -> o=8'hC0 then 8'h0F on consecutive cycles from cycle 3; ones_cnt=6.
- Backpressure: fill with 3 vectors, hold out_ready=0 for 5 cycles -> in_ready=0 after 3 accepts, o stable; release -> 3 results in order, no loss.
- Saturation, CNT_W=4: deliver 3 vectors of o=8'hFF -> ones_cnt=15, not 24 mod 16.
- Clear race: cnt_clear=1 in the same cycle as a transfer of o=8'h03 -> ones_cnt=0 next cycle.
- Reset mid-stream: rst_n=0 with 2 vectors in flight -> out_valid=0, o=0, ones_cnt=0 immediately; after release, no stale results emerge.
